// File: rtl/mvm_out_requant.sv
// mvm_out_requant: output stage behind the 4x4 matrix-vector multiplier.
// Rounds (half-up), arithmetic-shifts and saturates each 2*WIDTH result to
// OUT_WIDTH bits. It tags the last element of every ROWS-long vector and
// buffers the result in a DEPTH-entry FIFO, so a one-cycle output_ready drop
// never stalls the MAC.
// Optional build macro: MVM_OUT_RELU_EN. When it is defined, negative rounded
// values are clamped to zero before saturation. Negative values clamped this
// way are not counted as saturated.
module mvm_out_requant #(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 12,
    parameter int SHIFT     = 4,
    parameter int DEPTH     = 4,
    parameter int ROWS      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic [IN_WIDTH-1:0]  input_data,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [OUT_WIDTH-1:0] output_data,
    output logic                 output_last,
    output logic [15:0]          sat_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [PTR_W:0]         CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [ROW_W-1:0]       ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [IN_WIDTH:0]      ROUND    = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
    // Two's complement: -(max) - 1 == ~max
    localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_WIDTH-1:0]   OUT_MAX  = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]   OUT_MIN  = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    // FIFO storage: bit OUT_WIDTH carries the vector-last tag.
    logic [OUT_WIDTH:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic [ROW_W-1:0]     r_row;
    logic [15:0]          r_sat_count;

    logic [IN_WIDTH:0]        w_t;
    logic signed [IN_WIDTH:0] w_s;
    logic [OUT_WIDTH-1:0]     w_q;
    logic                     w_sat;
    logic                     w_last;
    logic                     w_push;
    logic                     w_pop;

    // Ready depends only on registered occupancy (and reset), never on output_ready.
    assign input_ready  = !reset && (r_count != CNT_FULL);
    assign output_valid = (r_count != '0);
    assign w_push       = input_valid && input_ready;
    assign w_pop        = output_valid && output_ready;
    assign w_last       = (r_row == ROW_LAST);

    // Head is read directly so a push into an empty FIFO is visible the next cycle.
    assign output_data  = output_valid ? r_mem[r_rd_ptr][OUT_WIDTH-1:0] : '0;
    assign output_last  = output_valid ? r_mem[r_rd_ptr][OUT_WIDTH] : 1'b0;
    assign sat_count    = r_sat_count;

    // Round half-up, arithmetic shift, then clamp into the OUT_WIDTH signed range.
    always_comb begin
        w_t   = {input_data[IN_WIDTH-1], input_data} + ROUND;
        w_s   = $signed(w_t) >>> SHIFT;
        w_q   = w_s[OUT_WIDTH-1:0];
        w_sat = 1'b0;
`ifdef MVM_OUT_RELU_EN
        if (w_s[IN_WIDTH]) begin
            w_q = '0;
        end else if (w_s > SAT_MAX) begin
            w_q   = OUT_MAX;
            w_sat = 1'b1;
        end
`else
        if (w_s > SAT_MAX) begin
            w_q   = OUT_MAX;
            w_sat = 1'b1;
        end else if (w_s < SAT_MIN) begin
            w_q   = OUT_MIN;
            w_sat = 1'b1;
        end
`endif
    end

    // FIFO data array write; contents need no reset since the head is gated by valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last, w_q};
        end
    end

    // Pointers, occupancy, row counter and the saturating saturation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_row       <= '0;
            r_sat_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_row    <= w_last ? '0 : r_row + ROW_W'(1);
                if (w_sat && (r_sat_count != 16'hFFFF)) begin
                    r_sat_count <= r_sat_count + 16'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_out_requant.sv
// Directed-vector bench for mvm_out_requant with hand-computed expectations.
module tb_mvm_out_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        input_valid;
    logic        input_ready;
    logic [23:0] input_data;
    logic        output_valid;
    logic        output_ready;
    logic [11:0] output_data;
    logic        output_last;
    logic [15:0] sat_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mvm_out_requant dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_last  (output_last),
        .sat_count    (sat_count)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge with reset released.
    task automatic do_reset();
        input_valid = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Single push into an empty FIFO with output_ready=1; head checked next cycle.
    task automatic push_check(input string tag, input logic [23:0] val,
                              input int exp, input logic exp_last);
        input_valid = 1'b1;
        input_data  = val;
        #1;
        check_eq({tag, "_rdy"}, input_ready, 1);
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        #1;
        check_eq({tag, "_vld"}, output_valid, 1);
        check_eq({tag, "_data"}, $signed(output_data), exp);
        check_eq({tag, "_last"}, output_last, exp_last);
        $display("xfer %s in=%0d out=%0d last=%0b", tag, $signed(val),
                 $signed(output_data), output_last);
    endtask

    initial begin
        int q_val[$];
        logic q_last[$];
        int next_k;
        int mrow;
        int cyc;
        logic m_push;
        logic m_pop;

        reset        = 1'b1;
        input_valid  = 1'b0;
        input_data   = '0;
        output_ready = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check_eq("rst_rdy",  input_ready, 0);
        check_eq("rst_vld",  output_valid, 0);
        check_eq("rst_data", output_data, 0);
        check_eq("rst_last", output_last, 0);
        check_eq("rst_sat",  sat_count, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_rdy_after", input_ready, 1);

        // Scenario 1: basic rounding, one result per cycle
        output_ready = 1'b1;
        push_check("s1_a", 24'd256, 16, 1'b0);
        push_check("s1_b", 24'd24, 2, 1'b0);
        push_check("s1_c", -24'sd24, -1, 1'b0);
        push_check("s1_d", 24'd7, 0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("s1_empty", output_valid, 0);
        check_eq("s1_sat", sat_count, 0);

        // Scenario 2: saturation both ways; two zeros complete the vector
        push_check("s2_pos", 24'd100000, 2047, 1'b0);
`ifdef MVM_OUT_RELU_EN
        push_check("s2_neg", -24'sd100000, 0, 1'b0);
        check_eq("s2_sat", sat_count, 1);
`else
        push_check("s2_neg", -24'sd100000, -2048, 1'b0);
        check_eq("s2_sat", sat_count, 2);
`endif
        push_check("s2_z0", 24'd0, 0, 1'b0);
        push_check("s2_z1", 24'd0, 0, 1'b1);
        @(posedge clk);
        @(negedge clk);

        // Scenario 3: fill while stalled, then drain
        output_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            input_valid = 1'b1;
            input_data  = 24'(k * 16);
            #1;
            check_eq("s3_fill_rdy", input_ready, 1);
            @(posedge clk);
            @(negedge clk);
        end
        input_data = 24'd80;
        #1;
        check_eq("s3_full_rdy", input_ready, 0);
        check_eq("s3_full_vld", output_valid, 1);
        check_eq("s3_head1", $signed(output_data), 1);
        check_eq("s3_head1_last", output_last, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("s3_stall_data", $signed(output_data), 1);
        check_eq("s3_stall_rdy", input_ready, 0);
        output_ready = 1'b1;
        #1;
        check_eq("s3_fullpop_rdy", input_ready, 0);
        $display("xfer s3 out=%0d last=%0b", $signed(output_data), output_last);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("s3_rdy_again", input_ready, 1);
        check_eq("s3_head2", $signed(output_data), 2);
        $display("xfer s3 out=%0d last=%0b", $signed(output_data), output_last);
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        #1;
        check_eq("s3_head3", $signed(output_data), 3);
        check_eq("s3_head3_last", output_last, 0);
        $display("xfer s3 out=%0d last=%0b", $signed(output_data), output_last);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("s3_head4", $signed(output_data), 4);
        check_eq("s3_head4_last", output_last, 1);
        $display("xfer s3 out=%0d last=%0b", $signed(output_data), output_last);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("s3_head5", $signed(output_data), 5);
        check_eq("s3_head5_last", output_last, 0);
        $display("xfer s3 out=%0d last=%0b", $signed(output_data), output_last);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("s3_empty", output_valid, 0);

        // Scenario 4: back-to-back pushes with output_ready toggling
        @(negedge clk);
        do_reset();
        next_k = 1;
        mrow   = 0;
        cyc    = 0;
        while ((next_k <= 8 || q_val.size() > 0) && cyc < 60) begin
            output_ready = (cyc % 2 == 0);
            input_valid  = (next_k <= 8);
            input_data   = 24'(next_k * 16);
            #1;
            check_eq("s4_rdy", input_ready, (q_val.size() != 4));
            check_eq("s4_vld", output_valid, (q_val.size() != 0));
            if (q_val.size() > 0) begin
                check_eq("s4_data", $signed(output_data), q_val[0]);
                check_eq("s4_last", output_last, q_last[0]);
            end
            m_push = input_valid && (q_val.size() != 4);
            m_pop  = (q_val.size() > 0) && output_ready;
            if (m_pop) begin
                $display("xfer s4 out=%0d last=%0b", q_val[0], q_last[0]);
                void'(q_val.pop_front());
                void'(q_last.pop_front());
            end
            if (m_push) begin
                q_val.push_back(next_k);
                q_last.push_back(mrow == 3);
                mrow   = (mrow + 1) % 4;
                next_k = next_k + 1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        input_valid = 1'b0;
        check_eq("s4_done_in_time", (cyc < 60), 1);

        // Scenario 5: reset mid-stream discards entries and restarts the row counter
        do_reset();
        output_ready = 1'b0;
        input_valid  = 1'b1;
        input_data   = 24'd100000;
        @(posedge clk);
        @(negedge clk);
        input_data = 24'd16;
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        #1;
        check_eq("s5_pre_vld", output_valid, 1);
        check_eq("s5_pre_head", $signed(output_data), 2047);
        check_eq("s5_pre_sat", sat_count, 1);
        reset = 1'b1;
        #1;
        check_eq("s5_rst_rdy", input_ready, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("s5_post_vld", output_valid, 0);
        check_eq("s5_post_sat", sat_count, 0);
        check_eq("s5_post_data", output_data, 0);
        check_eq("s5_post_rdy", input_ready, 1);
        output_ready = 1'b1;
        push_check("s5_a", 24'd48, 3, 1'b0);
        push_check("s5_b", 24'd64, 4, 1'b0);
        push_check("s5_c", 24'd80, 5, 1'b0);
        push_check("s5_d", 24'd96, 6, 1'b1);
        @(posedge clk);
        @(negedge clk);

        // Scenario 6: saturation counter sticks at 0xFFFF
        do_reset();
        output_ready = 1'b1;
        input_valid  = 1'b1;
        input_data   = 24'd100000;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("s6_sat_fffe", sat_count, 65534);
        check_eq("s6_head", $signed(output_data), 2047);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("s6_sat_ffff", sat_count, 65535);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("s6_sat_hold", sat_count, 65535);
        check_eq("s6_rdy", input_ready, 1);
        input_valid = 1'b0;
        $display("xfer s6 sat_count=%0d", sat_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
